// File: rtl/fft_frame_streamer.sv
// Frame streamer: buffers MAX_FRAMES frames of FFT_N complex samples and
// replays them with valid/SOF/EOF framing, optional inter-frame gaps and
// loop mode. Read path is address stage -> registered RAM read -> output regs.
module fft_frame_streamer #(
  parameter int DATA_W     = 9,
  parameter int FFT_N      = 32,
  parameter int MAX_FRAMES = 3,
  parameter int GAP_W      = 8,
  parameter int FRM_W      = 2,
  parameter int AW         = $clog2(FFT_N * MAX_FRAMES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_re,
  input  logic [DATA_W-1:0] wr_im,
  input  logic              start,
  input  logic              abort,
  input  logic              loop_en,
  input  logic [FRM_W-1:0]  num_frames,
  input  logic [GAP_W-1:0]  gap_cycles,
  input  logic              stall,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_re,
  output logic [DATA_W-1:0] out_im,
  output logic              out_sof,
  output logic              out_eof,
  output logic [FRM_W-1:0]  frame_idx,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = FFT_N * MAX_FRAMES;
  localparam int SW    = $clog2(FFT_N);

  typedef enum logic [1:0] {IDLE, STREAM, GAP, DONE} state_t;

  state_t                state, state_n;
  logic                  loop_q;
  logic [FRM_W-1:0]      nf_q, frame, nf_start;
  logic [GAP_W-1:0]      gap_q, gap_cnt;
  logic [SW-1:0]         samp;
  logic [AW-1:0]         rd_addr;
  logic                  issue, at_eof, at_last, wr_ok;
  logic                  p1_valid, p1_sof, p1_eof;
  logic [FRM_W-1:0]      p1_fidx;
  logic [2*DATA_W-1:0]   rd_data;
  logic [2*DATA_W-1:0]   mem [DEPTH];

  assign busy = (state != IDLE);

  // Next-state logic; issue marks a cycle where the address stage reads a sample
  always_comb begin
    state_n  = state;
    issue    = 1'b0;
    at_eof   = (samp == SW'(FFT_N - 1));
    at_last  = (frame == nf_q - FRM_W'(1));
    wr_ok    = (state == IDLE) && wr_en && (32'(wr_addr) < DEPTH);
    nf_start = (num_frames == '0 || 32'(num_frames) > MAX_FRAMES) ?
               FRM_W'(MAX_FRAMES) : num_frames;
    if (abort) begin
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:   if (start) state_n = STREAM;
        STREAM: if (!stall) begin
          issue = 1'b1;
          if (at_eof) begin
            if (at_last && !loop_q) state_n = DONE;
            else if (gap_q != '0)   state_n = GAP;
          end
        end
        GAP:    if (!stall && gap_cnt == '0) state_n = STREAM;
        // Wait until the last sample has left the read register so that
        // done lands in the cycle right after the final out_valid.
        DONE:   if (!stall && !p1_valid) state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end
  end

  // State register plus address, sample, frame and gap counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      loop_q  <= 1'b0;
      nf_q    <= '0;
      gap_q   <= '0;
      gap_cnt <= '0;
      frame   <= '0;
      samp    <= '0;
      rd_addr <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && start && !abort) begin
        loop_q  <= loop_en;
        nf_q    <= nf_start;
        gap_q   <= gap_cycles;
        frame   <= '0;
        samp    <= '0;
        rd_addr <= '0;
      end
      if (issue) begin
        if (at_eof) begin
          samp <= '0;
          if (at_last) begin
            frame   <= '0;
            rd_addr <= '0;
          end else begin
            frame   <= frame + FRM_W'(1);
            rd_addr <= rd_addr + AW'(1);
          end
          if (gap_q != '0) gap_cnt <= gap_q - GAP_W'(1);
        end else begin
          samp    <= samp + SW'(1);
          rd_addr <= rd_addr + AW'(1);
        end
      end
      if (state == GAP && !stall && !abort && gap_cnt != '0)
        gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  // Sample buffer: synchronous write while idle, registered read on issue
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= {wr_re, wr_im};
    if (issue) rd_data <= mem[rd_addr];
  end

  // Framing pipeline and output registers; stall freezes the read register
  // so the in-flight sample is held and replayed on release
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_valid  <= 1'b0;
      p1_sof    <= 1'b0;
      p1_eof    <= 1'b0;
      p1_fidx   <= '0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      frame_idx <= '0;
      done      <= 1'b0;
    end else if (abort) begin
      p1_valid  <= 1'b0;
      p1_sof    <= 1'b0;
      p1_eof    <= 1'b0;
      p1_fidx   <= '0;
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      frame_idx <= '0;
      done      <= 1'b0;
    end else if (!stall) begin
      p1_valid  <= issue;
      p1_sof    <= issue && (samp == '0);
      p1_eof    <= issue && at_eof;
      p1_fidx   <= frame;
      out_valid <= p1_valid;
      out_re    <= p1_valid ? rd_data[2*DATA_W-1 -: DATA_W] : '0;
      out_im    <= p1_valid ? rd_data[DATA_W-1:0] : '0;
      out_sof   <= p1_valid && p1_sof;
      out_eof   <= p1_valid && p1_eof;
      frame_idx <= p1_valid ? p1_fidx : frame_idx;
      done      <= (state == DONE) && !p1_valid;
    end else begin
      out_valid <= 1'b0;
      out_re    <= '0;
      out_im    <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      done      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_frame_streamer.sv
// Bench for fft_frame_streamer: table of pass configurations checked against
// a reference model of the sample/timing schedule, plus hand sequences for
// loop+abort, busy-time pokes, stall and mid-stream reset.
module tb_fft_frame_streamer;
  localparam int DATA_W = 9, FFT_N = 32, MAX_FRAMES = 3, GAP_W = 8, FRM_W = 2;
  localparam int DEPTH = FFT_N * MAX_FRAMES, AW = 7;

  logic              clk = 1'b0, rst;
  logic              wr_en, start, abort, loop_en, stall;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_re, wr_im;
  logic [FRM_W-1:0]  num_frames;
  logic [GAP_W-1:0]  gap_cycles;
  logic              out_valid, out_sof, out_eof, busy, done;
  logic [DATA_W-1:0] out_re, out_im;
  logic [FRM_W-1:0]  frame_idx;

  fft_frame_streamer #(.DATA_W(DATA_W), .FFT_N(FFT_N), .MAX_FRAMES(MAX_FRAMES),
                       .GAP_W(GAP_W), .FRM_W(FRM_W), .AW(AW)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_re(wr_re),
    .wr_im(wr_im), .start(start), .abort(abort), .loop_en(loop_en),
    .num_frames(num_frames), .gap_cycles(gap_cycles), .stall(stall),
    .out_valid(out_valid), .out_re(out_re), .out_im(out_im), .out_sof(out_sof),
    .out_eof(out_eof), .frame_idx(frame_idx), .busy(busy), .done(done));

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [DATA_W-1:0] bm_re [DEPTH];
  logic [DATA_W-1:0] bm_im [DEPTH];

  typedef struct {
    int nf;
    int g;
    int exp_samples;
    int exp_span;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input bit ramp);
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      wr_en   = 1'b1;
      wr_addr = AW'(a);
      wr_re   = ramp ? DATA_W'(a)  : DATA_W'($urandom);
      wr_im   = ramp ? DATA_W'(-a) : DATA_W'($urandom);
      bm_re[a] = wr_re;
      bm_im[a] = wr_im;
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // Leaves the bench at the falling edge following the edge that samples start
  task automatic pulse_start(input int nf, input int g, input bit lp);
    @(negedge clk);
    num_frames = FRM_W'(nf);
    gap_cycles = GAP_W'(g);
    loop_en    = lp;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // mode 0: no stall; 1: random stall; 2: stall 3 cycles once sample 10 is due
  task automatic run_pass(input int nf_in, input int g, input int mode, input bit poke,
                          output int n_valid, output int span);
    int nf, total, first, f, s, extra, stall_left;
    bit fin, stalled_once;
    nf = (nf_in == 0 || nf_in > MAX_FRAMES) ? MAX_FRAMES : nf_in;
    total = nf * FFT_N;
    n_valid = 0; span = -1; first = -1; fin = 0;
    stall_left = 0; stalled_once = 0; extra = 0;
    pulse_start(nf_in, g, 1'b0);
    stall = (mode == 1) && ($urandom_range(3) == 0);
    for (int k = 1; k < 4000 && !fin; k++) begin
      @(negedge clk);
      stall = 1'b0; wr_en = 1'b0; start = 1'b0;
      if (out_valid) begin
        f = n_valid / FFT_N;
        s = n_valid % FFT_N;
        if (n_valid >= total) begin
          check("sample_overrun", 64'(n_valid), 64'(total - 1));
          fin = 1;
        end else begin
          check("sample", {out_re, out_im, out_sof, out_eof, frame_idx, busy},
                {bm_re[n_valid], bm_im[n_valid], (s == 0), (s == FFT_N - 1), FRM_W'(f), 1'b1});
          extra = (mode == 2 && n_valid >= 10) ? 3 : 0;
          if (mode != 1) check("sample_time", 64'(k), 64'(2 + n_valid + g * f + extra));
        end
        if (first < 0) first = k;
        n_valid++;
      end else begin
        check("idle_zero", {out_re, out_im, out_sof, out_eof}, 64'(0));
      end
      if (done && !fin) begin
        check("done_count", 64'(n_valid), 64'(total));
        check("busy_at_done", 64'(busy), 64'(0));
        if (mode != 1) check("done_time", 64'(k), 64'(2 + total + g * (nf - 1) + (mode == 2 ? 3 : 0)));
        span = k - first;
        fin = 1;
      end
      if (poke && (k == 20 || k == 21)) begin
        start   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = (k == 20) ? AW'(70) : AW'(3);
        wr_re   = DATA_W'($urandom);
        wr_im   = DATA_W'($urandom);
      end
      if (mode == 2 && n_valid == 10 && !stalled_once) begin
        stall_left = 3;
        stalled_once = 1;
      end
      if (stall_left > 0) begin
        stall = 1'b1;
        stall_left--;
      end
      if (mode == 1) stall = ($urandom_range(3) == 0);
    end
    if (!fin) check("done_timeout", 64'(0), 64'(1));
    stall = 1'b0; wr_en = 1'b0; start = 1'b0;
  endtask

  initial begin
    int nv, sp, n, k, nf;
    tbl[0] = '{nf: 3, g: 0, exp_samples: 96, exp_span: 96};
    tbl[1] = '{nf: 2, g: 5, exp_samples: 64, exp_span: 69};
    tbl[2] = '{nf: 0, g: 0, exp_samples: 96, exp_span: 96};
    tbl[3] = '{nf: 1, g: 7, exp_samples: 32, exp_span: 32};
    tbl[4] = '{nf: 3, g: 1, exp_samples: 96, exp_span: 98};

    rst = 1'b1; wr_en = 0; start = 0; abort = 0; loop_en = 0; stall = 0;
    wr_addr = '0; wr_re = '0; wr_im = '0; num_frames = '0; gap_cycles = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {out_valid, out_re, out_im, out_sof, out_eof, frame_idx, busy, done}, 64'(0));
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {out_valid, busy, done}, 64'(0));

    load(1'b1);
    foreach (tbl[i]) begin
      run_pass(tbl[i].nf, tbl[i].g, 0, 1'b0, nv, sp);
      check("tbl_samples", 64'(nv), 64'(tbl[i].exp_samples));
      check("tbl_span", 64'(sp), 64'(tbl[i].exp_span));
    end

    // start and writes while streaming must be ignored
    run_pass(0, 0, 0, 1'b1, nv, sp);
    check("poke_samples", 64'(nv), 64'(96));
    run_pass(3, 0, 0, 1'b0, nv, sp);
    check("after_poke_samples", 64'(nv), 64'(96));

    // stall for three cycles around sample 10
    run_pass(1, 0, 2, 1'b0, nv, sp);
    check("stall3_samples", 64'(nv), 64'(32));

    // random contents and random stall
    load(1'b0);
    for (int i = 0; i < 4; i++) begin
      nf = $urandom_range(3);
      run_pass(nf, $urandom_range(6), 1, 1'b0, nv, sp);
      check("rand_stall_samples", 64'(nv), 64'(((nf == 0) ? 3 : nf) * FFT_N));
    end

    // loop mode, abort after 100 samples
    pulse_start(1, 0, 1'b1);
    n = 0;
    for (k = 1; k < 400 && n < 100; k++) begin
      @(negedge clk);
      if (out_valid) begin
        check("loop_sample", {out_re, out_im, out_sof, out_eof, frame_idx},
              {bm_re[n % FFT_N], bm_im[n % FFT_N], (n % FFT_N == 0), (n % FFT_N == FFT_N - 1), 2'd0});
        check("loop_time", 64'(k), 64'(2 + n));
        n++;
      end
      if (done) check("loop_no_done", 64'(done), 64'(0));
    end
    check("loop_reached_100", 64'(n), 64'(100));
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_state", {out_valid, out_re, out_im, out_sof, out_eof, frame_idx, busy, done}, 64'(0));
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("after_abort", {out_valid, busy, done}, 64'(0));
    end

    // asynchronous reset mid-stream at sample 40
    pulse_start(3, 0, 1'b0);
    n = 0;
    for (k = 1; k < 200 && n < 41; k++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    check("reached_sample_40", 64'(n), 64'(41));
    #2 rst = 1'b1;
    #1 check("async_reset", {out_valid, out_re, out_im, out_sof, out_eof, frame_idx, busy, done}, 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_mid_reset", {out_valid, busy, done}, 64'(0));
    run_pass(2, 3, 0, 1'b0, nv, sp);
    check("post_reset_samples", 64'(nv), 64'(64));
    check("post_reset_span", 64'(sp), 64'(67));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/fft_frame_streamer.md
Name: fft_frame_streamer

Overview:
- Synthesizable sample source that feeds the MDC FFT input port from an on-chip sample buffer.
- Holds up to MAX_FRAMES frames of FFT_N complex samples, loaded through a write port.
- On start, streams a programmable number of frames back-to-back, or with idle gap cycles between frames, with valid/SOF/EOF framing.
- Optional loop mode repeats until aborted; lets the FFT run in hardware without a behavioural bench driving the inputs.

Parameters:
DATA_W, 9, signed width of each real/imag sample
FFT_N, 32, samples per frame (power of 2, >=4)
MAX_FRAMES, 3, frames the buffer holds; DEPTH = FFT_N*MAX_FRAMES
GAP_W, 8, width of gap_cycles
FRM_W, 2, width of num_frames (must hold MAX_FRAMES)
AW, clog2(DEPTH), buffer address width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
wr_en  in  1  buffer write strobe; ignored unless state is IDLE
wr_addr  in  AW  buffer write address; writes with wr_addr >= DEPTH dropped
wr_re  in  DATA_W  real sample to write
wr_im  in  DATA_W  imag sample to write
start  in  1  single-cycle pulse; honoured only in IDLE
abort  in  1  return to IDLE at next edge from any state
loop_en  in  1  sampled at start; 1 = repeat sequence until abort
num_frames  in  FRM_W  frames per pass, sampled at start; 0 or >MAX_FRAMES clamps to MAX_FRAMES
gap_cycles  in  GAP_W  idle cycles between frames, sampled at start
stall  in  1  freezes streaming while high
out_valid  out  1  out_re/out_im carry a sample this cycle
out_re  out  DATA_W  sample real part (0 when out_valid low)
out_im  out  DATA_W  sample imag part (0 when out_valid low)
out_sof  out  1  first sample of a frame (qualified by out_valid)
out_eof  out  1  last sample of a frame (qualified by out_valid)
frame_idx  out  FRM_W  index of frame currently on output
busy  out  1  state is not IDLE
done  out  1  one-cycle pulse after last sample of a non-loop pass

Behaviour:
- Reset: state=IDLE; all outputs 0; read address, sample and frame counters 0; buffer contents undefined.
- Buffer: DEPTH x 2*DATA_W, synchronous write, registered read. Frame f occupies addresses f*FFT_N .. f*FFT_N+FFT_N-1.
- States: IDLE, STREAM, GAP, DONE.
- IDLE + start: latch loop_en, clamped num_frames (NF) and gap_cycles (G); go to STREAM at address 0.
- Latency: if start is sampled at edge E0, sample 0 is on the outputs after E2. From then on, one sample per unstalled cycle; samples within a frame are never separated by idle cycles.
- STREAM: issue one address per cycle. Sample counter wraps at FFT_N-1, which marks EOF.
  - EOF and G>0: go to GAP.
  - EOF, G=0, frames remain: continue directly with the next frame; no bubble.
  - EOF on the last frame: loop_en=1 restarts at frame 0 (through GAP if G>0); loop_en=0 goes to DONE.
- GAP: out_valid=0 for exactly G cycles after the EOF sample, then SOF of the next frame follows.
- DONE: done=1 for one cycle, aligned with the cycle after the last out_valid; then IDLE.
- Stall:
  - While stall=1: address, counters and the gap count hold; out_valid=0; data outputs 0.
  - Release: resumes with the sample that would have appeared next; no sample dropped or duplicated.
  - stall is applied at the address stage, so one pipelined sample may complete after stall rises; that sample is then held, not lost.
- Abort: at the next edge, state=IDLE and all outputs 0; no done pulse; has priority over stall and start.
- start while busy: ignored.
- wr_en while busy: ignored (buffer is read-only during streaming).
- frame_idx is valid while out_valid=1 and stable across a frame.

Test Plan:
- Load 96 samples, value = address (re), -address (im); num_frames=3, G=0, loop_en=0, start -> 96 consecutive valid cycles starting 2 edges after start; SOF at samples 0/32/64, EOF at 31/63/95, frame_idx 0,1,2; done pulse on cycle 97.
- Same load, G=5, num_frames=2 -> 32 valid, exactly 5 invalid, 32 valid (addresses 32..63), done; total 69 cycles from first valid to done.
- loop_en=1, num_frames=1, G=0 -> addresses 0..31 repeat continuously; abort after 100 samples -> out_valid=0 next cycle, busy=0, no done.
- stall high for 3 cycles during sample 10 -> data stream shows values 0..31 in order with no gaps or duplicates; out_valid low during the stall; EOF at value 31.
- num_frames=0 -> treated as 3 (96 samples); start pulsed again mid-stream and wr_en writes during STREAM -> no effect, buffer unchanged on the next pass.
- Assert rst mid-stream at sample 40 -> all outputs 0 immediately (asynchronously); after release, state IDLE; a new start streams from address 0.
